regfile_wb_ctrl: RTL
====================

# regfile_wb_ctrl

Writeback controller that owns the single write port of the 16x16 register file. It accepts destination-register results from two producers, the ALU and the memory/load unit, over valid/ready handshakes. Results are merged by round-robin into a small in-order queue and drained at most one per cycle as registered `we`/`wn`/`d` into the register file. An optional scoreboard reports which registers have a write still pending.

## Interface
Parameters:
- DEPTH, 4, queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on posedge
- clrn  in  1  asynchronous active-low reset
- a_valid  in  1  ALU result valid
- a_ready  out  1  ALU result accepted this cycle when a_valid & a_ready
- a_wn  in  4  ALU destination register
- a_d  in  16  ALU result data
- m_valid  in  1  memory result valid
- m_ready  out  1  memory result accepted when m_valid & m_ready
- m_wn  in  4  memory destination register
- m_d  in  16  memory result data
- wb_hold  in  1  when 1, queue does not drain
- we  out  1  register-file write enable (registered)
- wn  out  4  register-file write index (registered)
- d  out  16  register-file write data (registered)
- busy  out  16  per-register pending-write flags (see Configuration)

## Operation
- Queue: FIFO of {wn[3:0], d[15:0]}, DEPTH entries.
  - count: $clog2(DEPTH+1) bits.
  - Read and write pointers: $clog2(DEPTH) bits, wrapping modulo DEPTH.
- space = (count != DEPTH). Space is evaluated on registered count only; there is no pass-through when full, even if a pop occurs in the same cycle.
- Arbitration uses a 1-bit pointer `rr`: 1 = MEM has priority, 0 = ALU has priority.
  - m_ready = space & (!a_valid | rr)
  - a_ready = space & (!m_valid | !rr)
  - At most one push per cycle.
  - After every accepted push, rr points to the other source.
- Pop: when count != 0 and wb_hold == 0, the head entry loads into {wn, d}, we is set to 1, and the read pointer advances. Otherwise we = 0; wn and d hold their last values.
- Push and pop in the same cycle: count is unchanged.
- Commit order equals acceptance order. Writes to the same register are never reordered or merged.
- wn/d values are undefined-by-contract while we = 0. The bench checks them only when we = 1.

## Timing
- Reset (clrn low, asynchronous): the following outputs are effective immediately.
  - we = 0, wn = 0, d = 16'h0000
  - count = 0, both pointers = 0, rr = 1, busy = 16'h0000
  - Queued entries are discarded.
- After reset: a_ready = m_ready = 1 (combinational from registered state).
- Latency:
  - A result accepted at edge E0 is in the queue after E0.
  - If it is at the head and wb_hold = 0, we/wn/d present it after E1.
  - The register file commits it at E2.
- Throughput: 1 write/cycle sustained.
- wb_hold asserted: pops stop at the next edge, and we = 0 after that edge. Pushes continue until full.
- Handshake: the ready signals are combinational in the opposite source's valid. A producer holds valid, wn and d until accepted.

## Configuration
- `REGFILE_WB_SCOREBOARD_EN` defined:
  - busy[r] = 1 while any valid queue entry targets r, or while we = 1 with wn = r.
  - busy is combinational from registered state, so it clears in the cycle after the commit edge.
- Undefined: busy is tied to 16'h0000, and no scoreboard logic is built. The port remains, keeping the interface stable.

## Structure
- Shared package `tinygpu_pkg`:
  - REG_W = 16, REGN_W = 4, NREG = 16
  - typedef `wb_req_t` {wn, d}
  - src enum {SRC_ALU, SRC_MEM}
- Sub-module `wb_fifo`: parameterized DEPTH storage with count, push/pop, full/empty and per-entry valid/wn vectors (the vectors feed the scoreboard). Arbitration and the output register stay in `regfile_wb_ctrl`.

## Test plan
- Reset: assert clrn = 0 mid-traffic with 3 queued. Expect we = 0 and busy = 0 immediately; after release a_ready = m_ready = 1 and no stale writes ever appear.
- Single write: a_valid with a_wn = 2, a_d = 16'h0009 accepted at E0. Expect we = 1, wn = 2, d = 16'h0009 after E1, and we = 0 after E2.
- Contention after reset: a_valid & m_valid together.
  - MEM {3, 16'h00AA} is accepted first; ALU {4, 16'h1234} is accepted the next cycle.
  - Writes appear in order MEM then ALU on consecutive cycles.
- Full/hold: wb_hold = 1 with 4 ALU pushes {r1..r4, 16'h0001..16'h0004}.
  - Expect a_ready = 0 once count = 4.
  - Release wb_hold: expect 4 writes on consecutive cycles, in order.
  - a_ready returns to 1 the cycle after the first pop.
- Same register twice: ALU {7, 16'h1111} then MEM {7, 16'h2222}. Expect both committed in that order, with final d = 16'h2222.
- Scoreboard (with `REGFILE_WB_SCOREBOARD_EN`): push wn = 5 at E0.
  - busy[5] = 1 from after E0 through the we = 1 cycle, and 0 after E2.
  - Other busy bits stay 0.

Source files
------------

// File: rtl/tinygpu_pkg.sv
// Shared register-file geometry and writeback request types for the tinygpu datapath.
package tinygpu_pkg;

    localparam int REG_W  = 16;
    localparam int REGN_W = 4;
    localparam int NREG   = 16;

    typedef struct packed {
        logic [REGN_W-1:0] wn;
        logic [REG_W-1:0]  d;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback queue of {wn, d}; with REGFILE_WB_SCOREBOARD_EN it also exports
// per-slot valid/wn vectors so the owner can build a pending-write scoreboard.
module wb_fifo
    import tinygpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic                          push_i,
    input  wb_req_t                       push_data_i,
    input  logic                          pop_i,
`ifdef REGFILE_WB_SCOREBOARD_EN
    output logic [DEPTH-1:0]              ent_valid_o,
    output logic [DEPTH-1:0][REGN_W-1:0]  ent_wn_o,
`endif
    output wb_req_t                       head_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;
    wb_req_t       mem_q [DEPTH];

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_q];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_d  = wr_q + PW'(do_push);
        rd_d  = rd_q + PW'(do_pop);
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is not reset: a cleared count already makes every slot invalid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [PW-1:0] off;

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off            = PW'(i) - rd_q;
            ent_valid_o[i] = (CW'(off) < cnt_q);
            ent_wn_o[i]    = mem_q[i].wn;
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Round-robin ALU/MEM writeback merge into a queue that drains one registered write per cycle.
// Optional REGFILE_WB_SCOREBOARD_EN builds the per-register pending-write flags on busy.
module regfile_wb_ctrl
    import tinygpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [REGN_W-1:0] a_wn,
    input  logic [REG_W-1:0]  a_d,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [REGN_W-1:0] m_wn,
    input  logic [REG_W-1:0]  m_d,
    input  logic              wb_hold,
    output logic              we,
    output logic [REGN_W-1:0] wn,
    output logic [REG_W-1:0]  d,
    output logic [NREG-1:0]   busy
);

    logic              rr_q, rr_d;
    logic              we_q, we_d;
    logic [REGN_W-1:0] wn_q, wn_d;
    logic [REG_W-1:0]  d_q, d_d;
    logic              space, full, empty;
    logic              push_a, push_m, push, pop;
    src_e              push_src;
    wb_req_t           push_data, head;

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0][REGN_W-1:0] ent_wn;
`endif

    // rr_q = 1 gives MEM priority; readiness looks only at registered fullness.
    assign space     = ~full;
    assign m_ready   = space & (~a_valid | rr_q);
    assign a_ready   = space & (~m_valid | ~rr_q);
    assign push_m    = m_valid & m_ready;
    assign push_a    = a_valid & a_ready;
    assign push      = push_a | push_m;
    assign push_src  = push_m ? SRC_MEM : SRC_ALU;
    assign push_data = (push_src == SRC_MEM) ? {m_wn, m_d} : {a_wn, a_d};
    assign pop       = ~empty & ~wb_hold;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .clrn        (clrn),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
`ifdef REGFILE_WB_SCOREBOARD_EN
        .ent_valid_o (ent_valid),
        .ent_wn_o    (ent_wn),
`endif
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_comb begin
        rr_d = push ? (push_src == SRC_ALU) : rr_q;
        we_d = pop;
        wn_d = pop ? head.wn : wn_q;
        d_d  = pop ? head.d  : d_q;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rr_q <= 1'b1;
            we_q <= 1'b0;
            wn_q <= '0;
            d_q  <= '0;
        end else begin
            rr_q <= rr_d;
            we_q <= we_d;
            wn_q <= wn_d;
            d_q  <= d_d;
        end
    end

    assign we = we_q;
    assign wn = wn_q;
    assign d  = d_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
    // The in-flight write keeps its register busy until the commit edge.
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                busy[ent_wn[i]] = 1'b1;
            end
        end
        if (we_q) begin
            busy[wn_q] = 1'b1;
        end
    end
`else
    assign busy = '0;
`endif

endmodule
